// File: rtl/dir_button_conditioner.sv
// Conditions four raw direction buttons into debounced levels and one-hot,
// single-cycle press pulses; chords and held buttons never produce a pulse.
module dir_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int CNT_W           = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] btn_raw,
  output logic       bu_front,
  output logic       bu_back,
  output logic       bu_left,
  output logic       bu_right,
  output logic [3:0] btn_level,
  output logic       busy
);

  typedef enum logic {
    ARMED,
    HELD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [3:0]       sync1_reg, sync2_reg;
  logic [3:0]       level_reg, level_prev_reg;
  logic [3:0]       pulse_reg, pulse_next;
  logic [CNT_W-1:0] cnt_reg  [4];
  logic [CNT_W-1:0] cnt_next [4];
  logic [3:0]       differ, flip, rise;

  // Per-bit debounce: the count survives only while sync2 keeps disagreeing
  // with the debounced level, so any single agreeing cycle restarts it.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      assign differ[gi]   = sync2_reg[gi] ^ level_reg[gi];
      assign flip[gi]     = differ[gi] && (cnt_reg[gi] == CNT_MAX);
      assign cnt_next[gi] = (!differ[gi] || flip[gi]) ? '0 : cnt_reg[gi] + 1'b1;
    end
  endgenerate

  assign rise = level_reg & ~level_prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      level_reg      <= '0;
      level_prev_reg <= '0;
      pulse_reg      <= '0;
      state_reg      <= ARMED;
      for (int i = 0; i < 4; i++) cnt_reg[i] <= '0;
    end else begin
      sync1_reg      <= btn_raw;
      sync2_reg      <= sync1_reg;
      level_reg      <= level_reg ^ flip;
      level_prev_reg <= level_reg;
      pulse_reg      <= pulse_next;
      state_reg      <= state_next;
      for (int i = 0; i < 4; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  // A rise only fires when it is the sole active button; anything else
  // parks the FSM in HELD until every button is released.
  always_comb begin
    state_next = state_reg;
    pulse_next = '0;
    case (state_reg)
      ARMED: begin
        if (enable && (rise != 4'b0000)) begin
          state_next = HELD;
          if ($onehot(rise) && ((level_reg & ~rise) == 4'b0000)) pulse_next = rise;
        end
      end
      HELD: begin
        if (level_reg == 4'b0000) state_next = ARMED;
      end
      default: state_next = ARMED;
    endcase
  end

  assign bu_front  = pulse_reg[3];
  assign bu_back   = pulse_reg[2];
  assign bu_left   = pulse_reg[1];
  assign bu_right  = pulse_reg[0];
  assign btn_level = level_reg;
  assign busy      = (state_reg == HELD);

endmodule

// File: doc/dir_button_conditioner.md
Name: dir_button_conditioner

Overview:
- Upstream stage of the semi-auto driving controller. Conditions the four raw direction push-buttons: synchronise, debounce, detect presses.
- Delivers one-hot, single-cycle press pulses on bu_front/bu_back/bu_left/bu_right, which the controller decodes in its waiting state.
- Rejects chords and holds, so the controller never sees a multi-hot or repeated command.

Parameters:
- DEBOUNCE_CYCLES, 2000000, consecutive cycles a synchronised input must differ from its debounced level before that level flips (20 ms at 100 MHz); minimum 2.
- CNT_W, 32, width of each debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  pulse emission enable; tied to the semi-auto mode enable.
- btn_raw  input  4  raw buttons {front, back, left, right}, asynchronous, active-high.
- bu_front  output  1  single-cycle press pulse, front.
- bu_back  output  1  single-cycle press pulse, back.
- bu_left  output  1  single-cycle press pulse, left.
- bu_right  output  1  single-cycle press pulse, right.
- btn_level  output  4  debounced levels, same bit order as btn_raw.
- busy  output  1  high while in state HELD.

Behaviour:
- Reset (async, rst=1): sync flops, btn_level, all counters and all pulse outputs go to 0; FSM goes to ARMED; busy=0. Reset mid-debounce discards all progress.
- Synchroniser: two flops per bit; sync2 is the debounced path input.
- Debounce, per bit independently:
  - If sync2 == btn_level[i], the counter clears to 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, btn_level[i] toggles and the counter clears; else the counter increments.
  - Any single-cycle agreement restarts the count (glitch rejection).
- Rise event: rise[i] = btn_level[i] now 1 and previous-cycle value 0.
- FSM states:
  - ARMED: if rise has exactly one bit set, and every other btn_level bit is 0, and enable=1, assert the matching bu_* for exactly one cycle (registered, the cycle after btn_level rises) and go to HELD. If rise is multi-hot, or any other level is already high, emit nothing and go to HELD. If enable=0, emit nothing and stay ARMED; debounce keeps running.
  - HELD: no pulses; busy=1. Return to ARMED when btn_level == 4'b0000.
- Outputs: at most one bu_* high in any cycle. Each pulse is exactly one cycle wide. All bu_* are 0 whenever enable was 0 at the decision cycle.
- Latency: raw held high from sampling edge k → sync2 high after edge k+1 → btn_level high after edge k+1+DEBOUNCE_CYCLES → bu_* high for the cycle after edge k+2+DEBOUNCE_CYCLES.
- Release: a falling btn_level produces no pulse.
- enable dropping while in HELD does not affect the return to ARMED.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle, btn_raw=0 → all bu_*=0, btn_level=0, busy=0 for 50 cycles. Assert rst mid-debounce → btn_level stays 0 and the counter restarts.
- btn_raw=4'b1000 held from edge 0 → btn_level[3]=1 after edge 5; bu_front=1 only in the cycle after edge 6; busy=1 until release. Release → no pulse, return to ARMED.
- btn_raw=4'b0010 with 1-cycle low glitches every 3 cycles for 40 cycles → btn_level stays 0, no pulse. Then a clean hold → one bu_left pulse.
- btn_raw 4'b0100 and 4'b0001 rising on the same edge → no pulse, busy=1. Release both → ARMED. Then 4'b0001 alone → one bu_right pulse.
- Hold back (pulse issued), then press right while back is still held → no bu_right pulse; busy stays 1 until both are released.
- enable=0, press front → no pulse, busy=0, btn_level[3] follows the button. Set enable=1 while still held → no pulse (no new rise). Release and re-press → one bu_front pulse.
